fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: frame-buffer address width.
REQ-002 Parameter DATA_WIDTH, default 8: pixel width.
REQ-003 Parameter MAX_WR_BURST, default 4, legal range 1-15: consecutive write grants allowed while a read waits.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  camera writer requests a write.
REQ-007 wr_addr  input  ADDR_WIDTH  write address.
REQ-008 wr_data  input  DATA_WIDTH  write pixel.
REQ-009 wr_ready  output  1  write granted this cycle.
REQ-010 rd_valid  input  1  mapping reader requests a read.
REQ-011 rd_addr  input  ADDR_WIDTH  read address.
REQ-012 rd_ready  output  1  read granted this cycle.
REQ-013 rd_data_valid  output  1  rd_data holds the result of the read granted in the previous cycle.
REQ-014 rd_data  output  DATA_WIDTH  read pixel, driven directly from ram_dout.
REQ-015 ram_en, ram_we  output  1 each  RAM port enable and write enable.
REQ-016 ram_addr  output  ADDR_WIDTH  RAM port address.
REQ-017 ram_din  output  DATA_WIDTH  RAM port write data.
REQ-018 ram_dout  input  DATA_WIDTH  RAM registered read data, 1-cycle latency.

Function
REQ-019 The block SHALL share one RAM port between the two requesters and grant at most one request per cycle.
REQ-020 A transfer SHALL occur when valid and ready are both high in the same cycle; ready SHALL never be high while its own valid is low.
REQ-021 wr_ready and rd_ready SHALL be combinational from the current valids and the registered burst counter.
REQ-022 When only one requester is valid, that requester SHALL be granted.
REQ-023 When both are valid and burst_cnt < MAX_WR_BURST, the write SHALL be granted; when burst_cnt = MAX_WR_BURST, the read SHALL be granted.
REQ-024 burst_cnt (4-bit) SHALL increment on a write grant while rd_valid=1, clear on any read grant, clear in any cycle with rd_valid=0, and never exceed MAX_WR_BURST.
REQ-025 On a write grant: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
REQ-026 On a read grant: ram_en=1, ram_we=0, ram_addr=rd_addr, and ram_din=0.
REQ-027 With no grant: ram_en=0, ram_we=0, ram_addr=0, and ram_din=0.
REQ-028 rd_data_valid SHALL be a register set to 1 exactly one cycle after each read grant and 0 otherwise; back-to-back read grants SHALL produce back-to-back valid data.
REQ-029 A read to the address written in the previous cycle SHALL return the new data; no forwarding logic is required because the grants are serialized.
REQ-030 The reader SHALL not be back-pressured: rd_data_valid carries no ready signal.

Reset
REQ-031 While reset=1: burst_cnt=0, rd_data_valid=0, wr_ready=0, rd_ready=0, and ram_en=0 regardless of the valids.
REQ-032 A read granted in the cycle before reset is asserted SHALL NOT produce rd_data_valid in the reset cycle.
REQ-033 In the first cycle after reset deasserts, arbitration SHALL proceed normally with burst_cnt=0.

Structure
REQ-034 Package fb_pkg SHALL hold FB_ADDR_WIDTH (17), FB_DATA_WIDTH (8), and FB_MAX_WR_BURST (4), which serve as the parameter defaults.
REQ-035 The block SHALL be a single module with no sub-modules; the RAM SHALL be instantiated by the parent and connected to port A.

Verification
REQ-036 Write only: wr_valid=1 at addresses 0..3 with data 0x10..0x13 -> wr_ready=1 every cycle, ram_we=1, ram_addr 0..3; a later read of address 2 returns 0x12 with one cycle of latency.
REQ-037 Both requesters continuously valid, MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating, with rd_data_valid high the cycle after each R.
REQ-038 Read only at address 5 following a write of 0xA5 to address 5 in the previous cycle -> rd_data=0xA5 with rd_data_valid=1 exactly one cycle after rd_ready.
REQ-039 rd_valid drops after 2 contested write grants and rises again -> burst_cnt restarts at 0, and the read waits a full 4 write grants.
REQ-040 Reset asserted in the cycle following a read grant -> rd_data_valid=0, all ready outputs 0, ram_en=0; the first post-reset contested cycle grants the write.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer port constants; these are the arbiter's parameter defaults.
package fb_pkg;
    localparam int FB_ADDR_WIDTH   = 17;
    localparam int FB_DATA_WIDTH   = 8;
    localparam int FB_MAX_WR_BURST = 4;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: writer/reader request channels plus the shared RAM port A.
interface fb_port_arbiter_if import fb_pkg::*; #(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) ();
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_data_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
        output wr_ready, rd_ready, rd_data_valid, rd_data, ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
        input  wr_ready, rd_ready, rd_data_valid, rd_data, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one RAM port between camera writer and map reader,
// writes win contention until MAX_WR_BURST consecutive grants have starved the reader.
module fb_port_arbiter import fb_pkg::*; #(
    parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = FB_DATA_WIDTH,
    parameter int MAX_WR_BURST = FB_MAX_WR_BURST
) (
    input logic clk,
    input logic reset,
    fb_port_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WR_BURST);

    logic [3:0] burst_cnt;
    logic       rd_pend;
    logic       grant_w;
    logic       grant_r;

    always_comb begin
        grant_w           = !reset && bus.wr_valid && (!bus.rd_valid || burst_cnt < MAX_CNT);
        grant_r           = !reset && bus.rd_valid && (!bus.wr_valid || burst_cnt >= MAX_CNT);
        bus.wr_ready      = grant_w;
        bus.rd_ready      = grant_r;
        bus.ram_en        = grant_w || grant_r;
        bus.ram_we        = grant_w;
        bus.ram_addr      = grant_w ? bus.wr_addr : grant_r ? bus.rd_addr : ADDR_WIDTH'(0);
        bus.ram_din       = grant_w ? bus.wr_data : DATA_WIDTH'(0);
        bus.rd_data       = bus.ram_dout;
        // a read granted just before reset must not surface during the reset cycle
        bus.rd_data_valid = rd_pend && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend   <= grant_r;
            burst_cnt <= (!bus.rd_valid || grant_r) ? '0
                       : (grant_w && burst_cnt < MAX_CNT) ? burst_cnt + 4'd1 : burst_cnt;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: table-driven directed check of the frame-buffer port arbiter with a RAM model.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    typedef struct {
        logic        rst;
        logic        wv;
        logic        rv;
        logic [16:0] wa;
        logic [7:0]  wd;
        logic [16:0] ra;
        logic        ewr;
        logic        err;
        logic        erdv;
        logic [7:0]  erd;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] mem [256];
    vec_t vecs [$];

    fb_port_arbiter_if #(.ADDR_WIDTH(FB_ADDR_WIDTH), .DATA_WIDTH(FB_DATA_WIDTH)) bus ();

    fb_port_arbiter #(
        .ADDR_WIDTH(FB_ADDR_WIDTH),
        .DATA_WIDTH(FB_DATA_WIDTH),
        .MAX_WR_BURST(FB_MAX_WR_BURST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // single-port RAM with registered read, 1-cycle latency
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_din;
        if (bus.ram_en && !bus.ram_we) bus.ram_dout <= mem[bus.ram_addr[7:0]];
    end

    function automatic vec_t mk(logic rst, logic wv, logic rv, logic [16:0] wa, logic [7:0] wd,
                                logic [16:0] ra, logic ewr, logic err, logic erdv, logic [7:0] erd);
        vec_t v;
        v.rst = rst; v.wv = wv; v.rv = rv; v.wa = wa; v.wd = wd; v.ra = ra;
        v.ewr = ewr; v.err = err; v.erdv = erdv; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        bus.wr_valid = v.wv;
        bus.rd_valid = v.rv;
        bus.wr_addr  = v.wa;
        bus.wr_data  = v.wd;
        bus.rd_addr  = v.ra;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        check("wr_ready", idx, 32'(bus.wr_ready), 32'(v.ewr));
        check("rd_ready", idx, 32'(bus.rd_ready), 32'(v.err));
        check("rd_data_valid", idx, 32'(bus.rd_data_valid), 32'(v.erdv));
        check("ram_en", idx, 32'(bus.ram_en), 32'(v.ewr | v.err));
        check("ram_we", idx, 32'(bus.ram_we), 32'(v.ewr));
        check("ram_addr", idx, 32'(bus.ram_addr), v.ewr ? 32'(v.wa) : v.err ? 32'(v.ra) : 32'd0);
        check("ram_din", idx, 32'(bus.ram_din), v.ewr ? 32'(v.wd) : 32'd0);
        if (v.erdv) check("rd_data", idx, 32'(bus.rd_data), 32'(v.erd));
    endtask

    initial begin
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        // reset with both requesting, then plain writes 0..3 and a read-back
        vecs.push_back(mk(1, 1, 1, 17'h0, 8'h00, 17'h0, 0, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 1, 0, 17'(k), 8'(8'h10 + k), 17'h0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 1, 17'h0, 8'h00, 17'h2, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 17'h0, 8'h00, 17'h0, 0, 0, 1, 8'h12));
        // write then immediate read of the same address
        vecs.push_back(mk(0, 1, 0, 17'h5, 8'hA5, 17'h0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 1, 17'h0, 8'h00, 17'h5, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 17'h0, 8'h00, 17'h0, 0, 0, 1, 8'hA5));
        // continuous contention: W,W,W,W,R repeating
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 1, 1, 17'(8'h40 + k), 8'(8'h20 + k), 17'h0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h44, 8'h24, 17'h0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h45, 8'h25, 17'h0, 1, 0, 1, 8'h10));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 1, 1, 17'(8'h46 + k), 8'(8'h26 + k), 17'h0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h49, 8'h29, 17'h0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h4A, 8'h2A, 17'h0, 1, 0, 1, 8'h10));
        // reader drops after 2 contested writes; counter restarts, read waits 4 writes
        vecs.push_back(mk(0, 0, 0, 17'h0, 8'h00, 17'h0, 0, 0, 0, 8'h00));
        for (int k = 0; k < 2; k++) vecs.push_back(mk(0, 1, 1, 17'(8'h50 + k), 8'(8'h30 + k), 17'h3, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 0, 17'h52, 8'h32, 17'h3, 1, 0, 0, 8'h00));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 1, 1, 17'(8'h53 + k), 8'(8'h33 + k), 17'h3, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h57, 8'h37, 17'h3, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 17'h0, 8'h00, 17'h0, 0, 0, 1, 8'h13));
        // read grant immediately followed by reset, then contested restart
        vecs.push_back(mk(0, 0, 1, 17'h0, 8'h00, 17'h2, 0, 1, 0, 8'h00));
        vecs.push_back(mk(1, 1, 1, 17'h60, 8'h40, 17'h2, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 1, 17'h61, 8'h41, 17'h2, 1, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

        // back-to-back reads of 0..3 must yield back-to-back valid data
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            reset = 1'b0;
            bus.wr_valid = 1'b0;
            bus.rd_valid = (k < 4);
            bus.rd_addr  = 17'(k);
            #1;
            check("b2b rd_ready", 100 + k, 32'(bus.rd_ready), (k < 4) ? 32'd1 : 32'd0);
            check("b2b rd_data_valid", 100 + k, 32'(bus.rd_data_valid), (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) check("b2b rd_data", 100 + k, 32'(bus.rd_data), 32'(8'h10 + k - 1));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
